// File: rtl/red_tree_pipe_pkg.sv
// ---------------------------------------------------------------------------
// red_pkg
//   Shared constants and helpers for the lane-reduction pipeline.
//   - clog2: constant function usable in parameter/localparam expressions.
//   - TERMS / LEVELS / SUM_W: derived sizes for the default configuration
//     (DATA_W=16, LANE_W=8). Parameterised instances recompute their own
//     values with clog2.
//   - RED_UNSIGNED / RED_SIGNED: encodings of the per-op lane mode bit.
// ---------------------------------------------------------------------------
package red_pkg;

  // Smallest r such that 2**r >= v (clog2(1) = 0).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam logic RED_UNSIGNED = 1'b0;
  localparam logic RED_SIGNED   = 1'b1;

  localparam int DATA_W_DEF = 16;
  localparam int LANE_W_DEF = 8;

  localparam int TERMS  = 2 * DATA_W_DEF / LANE_W_DEF;
  localparam int LEVELS = clog2(TERMS);
  localparam int SUM_W  = LANE_W_DEF + LEVELS;

endpackage

// File: rtl/red_tree_pipe_add_stage.sv
// ---------------------------------------------------------------------------
// red_add_stage
//   One level of the reduction tree. Adds adjacent pairs of IN_N input terms
//   of IN_W bits each into IN_N/2 registered terms of IN_W+1 bits. Each term
//   is widened by one bit before the add: sign-extended when the op's mode is
//   signed, zero-extended otherwise, so the sum can never overflow.
//   Payload, valid, mode and clr all advance together only when adv=1.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   adv        in   global pipeline advance enable
//   in_valid   in   slot at the stage input holds an op
//   in_mode    in   1: terms are two's complement, 0: unsigned
//   in_clr     in   accumulator-clear flag travelling with the op
//   in_data    in   IN_N terms, term j at [j*IN_W +: IN_W]
//   out_valid  out  registered valid
//   out_mode   out  registered mode
//   out_clr    out  registered clr flag
//   out_data   out  IN_N/2 terms, term j at [j*(IN_W+1) +: IN_W+1]
// ---------------------------------------------------------------------------
module red_add_stage #(
  parameter int IN_N = 4,
  parameter int IN_W = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              adv,
  input  logic                              in_valid,
  input  logic                              in_mode,
  input  logic                              in_clr,
  input  logic [IN_N*IN_W-1:0]              in_data,
  output logic                              out_valid,
  output logic                              out_mode,
  output logic                              out_clr,
  output logic [(IN_N/2)*(IN_W+1)-1:0]      out_data
);

  localparam int OUT_N = IN_N / 2;
  localparam int OUT_W = IN_W + 1;

  logic [OUT_N*OUT_W-1:0] sum_d;
  logic [IN_W-1:0]        lo;
  logic [IN_W-1:0]        hi;

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sum_d = '0;
    lo    = '0;
    hi    = '0;
    for (int i = 0; i < OUT_N; i++) begin
      lo = in_data[(2*i)*IN_W +: IN_W];
      hi = in_data[(2*i+1)*IN_W +: IN_W];
      // Widen by one bit: the MSB is replicated only for signed ops.
      sum_d[i*OUT_W +: OUT_W] = {in_mode & lo[IN_W-1], lo}
                              + {in_mode & hi[IN_W-1], hi};
    end
  end

  // NOTE: state is updated with non-blocking assignments so every stage
  // samples its neighbours' pre-edge values and the pipe shifts as one.
  // Payload is reset as well, because the last stage feeds sum_o, which must
  // read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_clr   <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_clr   <= in_clr;
      out_data  <= sum_d;
    end
  end

endmodule

// File: rtl/red_tree_pipe.sv
// ---------------------------------------------------------------------------
// red_tree_pipe
//   Pipelined lane-reduction unit (the RED execution unit in EX). Splits A and
//   B into LANE_W lanes (A lanes low-to-high, then B lanes low-to-high) and
//   returns the sum of all TERMS lanes, extended to RES_W. Lanes are unsigned
//   or two's complement per op. One adder level per register stage; the whole
//   pipe stalls globally when the output is held.
//
//   Build option: define RED_ACC_EN to add an accumulator stage after the
//   tree (latency LEVELS+1). sum_o then shows the running accumulator, which
//   each op optionally clears first via acc_clr_i. Without RED_ACC_EN the
//   last tree stage is the output register and acc_clr_i is ignored.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operands/mode valid this cycle
//   in_ready   out  unit accepts operands this cycle
//   a_i        in   operand A (DATA_W)
//   b_i        in   operand B (DATA_W)
//   signed_i   in   1: lanes are two's complement, 0: unsigned
//   acc_clr_i  in   clear accumulator before this op (RED_ACC_EN only)
//   out_valid  out  sum_o holds a result
//   out_ready  in   consumer takes the result this cycle
//   sum_o      out  reduction result (RES_W)
// ---------------------------------------------------------------------------
module red_tree_pipe
  import red_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANE_W = 8,
  parameter int RES_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              signed_i,
  input  logic              acc_clr_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  sum_o
);

  localparam int N_TERMS  = 2 * DATA_W / LANE_W;
  localparam int N_LEVELS = clog2(N_TERMS);
  localparam int N_SUM_W  = LANE_W + N_LEVELS;

  // Global advance: the pipe moves whenever the output slot is free or being
  // taken this cycle. A bubble in the output slot never blocks the pipe.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Lane 0 is A's low lane; B's lanes follow A's.
  logic [N_TERMS*LANE_W-1:0] lanes;
  assign lanes = {b_i, a_i};

  for (genvar k = 0; k < N_LEVELS; k++) begin : g_lvl
    localparam int IN_N = N_TERMS >> k;
    localparam int IN_W = LANE_W + k;

    logic [IN_N*IN_W-1:0]             in_d;
    logic                             in_v;
    logic                             in_m;
    logic                             in_c;
    logic [(IN_N/2)*(IN_W+1)-1:0]     data;
    logic                             valid;
    logic                             mode;
    logic                             clr;

    if (k == 0) begin : g_first
      // Stage 0 captures only on adv, so in_valid alone marks an accept.
      assign in_d = lanes;
      assign in_v = in_valid;
      assign in_m = signed_i;
      assign in_c = acc_clr_i;
    end else begin : g_rest
      assign in_d = g_lvl[k-1].data;
      assign in_v = g_lvl[k-1].valid;
      assign in_m = g_lvl[k-1].mode;
      assign in_c = g_lvl[k-1].clr;
    end

    red_add_stage #(
      .IN_N (IN_N),
      .IN_W (IN_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv),
      .in_valid  (in_v),
      .in_mode   (in_m),
      .in_clr    (in_c),
      .in_data   (in_d),
      .out_valid (valid),
      .out_mode  (mode),
      .out_clr   (clr),
      .out_data  (data)
    );
  end

  logic [N_SUM_W-1:0] sum_last;
  logic               valid_last;
  logic               mode_last;
  logic               clr_last;
  logic [RES_W-1:0]   ext_sum;

  assign sum_last   = g_lvl[N_LEVELS-1].data;
  assign valid_last = g_lvl[N_LEVELS-1].valid;
  assign mode_last  = g_lvl[N_LEVELS-1].mode;
  assign clr_last   = g_lvl[N_LEVELS-1].clr;

  // Extend the tree sum to RES_W using the mode that travelled with it.
  always_comb begin
    ext_sum = RES_W'(sum_last);
    if (mode_last == RED_SIGNED) ext_sum = RES_W'($signed(sum_last));
  end

`ifdef RED_ACC_EN
  logic [RES_W-1:0] acc_q;
  logic             acc_valid_q;

  // The accumulator changes only when a real op enters the output register;
  // bubbles pass through without touching it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
    end else if (adv) begin
      acc_valid_q <= valid_last;
      if (valid_last) acc_q <= (clr_last ? '0 : acc_q) + ext_sum;
    end
  end

  assign out_valid = acc_valid_q;
  assign sum_o     = acc_q;
`else
  // The last tree stage is the output register; the clr flag has no consumer.
  logic unused_clr;
  assign unused_clr = clr_last;

  assign out_valid = valid_last;
  assign sum_o     = ext_sum;
`endif

endmodule

// File: tb/tb_red_tree_pipe.sv
// ---------------------------------------------------------------------------
// tb_red_tree_pipe
//   Directed bench for red_tree_pipe at default parameters. Expected results
//   are hand-computed constants queued in issue order and compared as each
//   result retires. Define RED_ACC_EN for both bench and RTL to exercise the
//   accumulator build.
// ---------------------------------------------------------------------------
module tb_red_tree_pipe;

`ifdef RED_ACC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        signed_i;
  logic        acc_clr_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum_o;

  always #5 clk = ~clk;

  red_tree_pipe #(
    .DATA_W (16),
    .LANE_W (8),
    .RES_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .signed_i  (signed_i),
    .acc_clr_i (acc_clr_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_o     (sum_o)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          acc_cyc;
  logic        last_acc;
  logic [15:0] held;
  logic [15:0] exp_q[$];
  int          ret_cyc[$];
  int          b2b_acc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge (retire check, accept flag), then
  // step past the rising edge.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", 32'(sum_o), 32'(e));
        ret_cyc.push_back(cyc);
      end else begin
        check("no_spurious_out", 32'(out_valid), 32'(0));
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Offer one op and hold it until accepted (bounded). in_valid stays high so
  // consecutive calls issue on consecutive cycles.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic clr, input logic [15:0] exp, input logic want);
    int n;
    a_i       = a;
    b_i       = b;
    signed_i  = s;
    acc_clr_i = clr;
    in_valid  = 1'b1;
    if (want) exp_q.push_back(exp);
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    check("accepted", 32'(last_acc), 32'(1));
    acc_cyc = cyc;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 30) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a_i       = '0;
    b_i       = '0;
    signed_i  = 1'b0;
    acc_clr_i = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, reset-exit cycle
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_sum_o",     32'(sum_o),     32'(0));
    check("rst_in_ready",  32'(in_ready),  32'(1));

    // 1: basic unsigned op and latency
    ret_cyc.delete();
    send(16'h0102, 16'h0304, 1'b0, 1'b1, 16'h000A, 1'b1);
    in_valid = 1'b0;
    drain("t1_drain");
    check("t1_latency", (ret_cyc.size() > 0) ? ret_cyc[0] - acc_cyc + 1 : -1, LAT);

    // 2: extremes, unsigned vs signed
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h03FC, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFC, 1'b1);
    send(16'h8080, 16'h8080, 1'b1, 1'b1, 16'hFE00, 1'b1);
    send(16'h7F7F, 16'h7F7F, 1'b1, 1'b1, 16'h01FC, 1'b1);
    in_valid = 1'b0;
    drain("t2_drain");

    // 3: back-to-back, results on consecutive cycles
    ret_cyc.delete();
    b2b_acc.delete();
    send(16'h0102, 16'h0304, 1'b0, 1'b1, 16'h000A, 1'b1); b2b_acc.push_back(acc_cyc);
    send(16'h1020, 16'h3040, 1'b0, 1'b1, 16'h00A0, 1'b1); b2b_acc.push_back(acc_cyc);
    send(16'hFF01, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b1); b2b_acc.push_back(acc_cyc);
    in_valid = 1'b0;
    drain("t3_drain");
    check("t3_accept_gap1", b2b_acc[1] - b2b_acc[0], 1);
    check("t3_accept_gap2", b2b_acc[2] - b2b_acc[1], 1);
    check("t3_count", ret_cyc.size(), 3);
    if (ret_cyc.size() == 3) begin
      check("t3_result_gap1", ret_cyc[1] - ret_cyc[0], 1);
      check("t3_result_gap2", ret_cyc[2] - ret_cyc[1], 1);
    end

    // 4: stall with two ops in flight, new op offered during the stall
    send(16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b1);
    send(16'h0203, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int n = 0; n < 10 && !out_valid; n++) tick();
    check("t4_head_valid", 32'(out_valid), 32'(1));
    check("t4_head_sum",   32'(sum_o),     32'(16'h0001));
    held      = sum_o;
    a_i       = 16'h0404;
    b_i       = 16'h0404;
    signed_i  = 1'b0;
    acc_clr_i = 1'b1;
    in_valid  = 1'b1;
    exp_q.push_back(16'h0010);
    for (int n = 0; n < 5; n++) begin
      tick();
      check("t4_in_ready_low", 32'(in_ready),  32'(0));
      check("t4_valid_hold",   32'(out_valid), 32'(1));
      check("t4_sum_hold",     32'(sum_o),     32'(held));
      check("t4_no_accept",    32'(last_acc),  32'(0));
    end
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (last_acc) break;
    end
    check("t4_accept_after_release", 32'(last_acc), 32'(1));
    in_valid = 1'b0;
    drain("t4_drain");

    // 5: reset one cycle after accept drops the op
    send(16'h1111, 16'h1111, 1'b0, 1'b1, 16'h0000, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      check("t5_no_valid", 32'(out_valid), 32'(0));
    end
    send(16'h0102, 16'h0304, 1'b0, 1'b1, 16'h000A, 1'b1);
    in_valid = 1'b0;
    drain("t5_drain");

`ifdef RED_ACC_EN
    // 6: accumulator clear / accumulate / clear
    ret_cyc.delete();
    send(16'h0102, 16'h0304, 1'b0, 1'b1, 16'h000A, 1'b1);
    in_valid = 1'b0;
    drain("t6_op1");
    check("t6_latency", (ret_cyc.size() > 0) ? ret_cyc[0] - acc_cyc + 1 : -1, LAT);
    send(16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0014, 1'b1);
    send(16'h0102, 16'h0304, 1'b0, 1'b1, 16'h000A, 1'b1);
    in_valid = 1'b0;
    drain("t6_drain");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
